// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the KGP-RISC core: stretches the core reset and
// issues a registered per-cycle clock enable for the halt, free-run, single-step and run-N modes.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int PC_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] run_len,
    input  logic [PC_W-1:0]  pc,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_rst,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycles
);
    localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_FREE,
        S_STEP,
        S_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [RCW-1:0]   rst_cnt_reg, rst_cnt_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0] cyc_reg, cyc_next;
    logic             ce_reg, ce_next;
    logic             done_reg, done_next;
    logic             bp_reg, bp_next;
    logic             bp_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_RESET;
            rst_cnt_reg <= RCW'(RST_CYCLES);
            rem_reg     <= '0;
            cyc_reg     <= '0;
            ce_reg      <= 1'b0;
            done_reg    <= 1'b0;
            bp_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
            rem_reg     <= rem_next;
            cyc_reg     <= cyc_next;
            ce_reg      <= ce_next;
            done_reg    <= done_next;
            bp_reg      <= bp_next;
        end
    end

    // Breakpoint only qualifies on a cycle the core actually executes.
    assign bp_cond = ce_reg && bp_en && (pc == bp_addr);

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        rem_next     = rem_reg;
        cyc_next     = cyc_reg;
        ce_next      = 1'b0;
        done_next    = 1'b0;
        bp_next      = bp_reg;

        if (ce_reg && (cyc_reg != {CNT_W{1'b1}})) begin
            cyc_next = cyc_reg + CNT_W'(1);
        end

        unique case (state_reg)
            S_RESET: begin
                if (rst_cnt_reg <= RCW'(1)) begin
                    state_next = S_IDLE;
                end else begin
                    rst_cnt_next = rst_cnt_reg - RCW'(1);
                end
            end
            S_IDLE: begin
                if (start && !halt_req) begin
                    cyc_next = '0;
                    bp_next  = 1'b0;
                    unique case (mode)
                        2'd1: begin
                            state_next = S_FREE;
                            ce_next    = 1'b1;
                        end
                        2'd2: state_next = S_STEP;
                        2'd3: begin
                            if (run_len == '0) begin
                                done_next = 1'b1;
                            end else begin
                                state_next = S_RUN;
                                ce_next    = 1'b1;
                                rem_next   = run_len - CNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_FREE, S_STEP, S_RUN: begin
                if (halt_req) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else if (bp_cond) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                    bp_next    = 1'b1;
                end else if (state_reg == S_FREE) begin
                    ce_next = 1'b1;
                end else if (state_reg == S_RUN) begin
                    // rem counts enables still to issue after the current one
                    if (rem_reg == '0) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        ce_next  = 1'b1;
                        rem_next = rem_reg - CNT_W'(1);
                    end
                end else begin
                    ce_next = step_req && !ce_reg;
                end
            end
            default: state_next = S_RESET;
        endcase
    end

    assign cpu_rst = (state_reg == S_RESET);
    assign busy    = (state_reg == S_FREE) || (state_reg == S_STEP) || (state_reg == S_RUN);
    assign cpu_ce  = ce_reg;
    assign done    = done_reg;
    assign bp_hit  = bp_reg;
    assign cycles  = cyc_reg;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset stretch, RUN_N, STEP, breakpoint,
// halt/breakpoint priority, asynchronous mid-run reset and counter saturation.
module tb_cpu_run_ctrl;
    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        start;
    logic        step_req;
    logic        halt_req;
    logic [15:0] run_len;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_rst, cpu_ce, busy, done, bp_hit;
    logic [15:0] cycles;
    logic        s_cpu_rst, s_cpu_ce, s_busy, s_done, s_bp_hit;
    logic [3:0]  s_cycles;
    logic        pc_clr;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_req(step_req),
        .halt_req(halt_req), .run_len(run_len), .pc(pc), .bp_en(bp_en),
        .bp_addr(bp_addr), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .busy(busy),
        .done(done), .bp_hit(bp_hit), .cycles(cycles)
    );

    cpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(4), .PC_W(32)) dut_sat (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_req(step_req),
        .halt_req(halt_req), .run_len(run_len[3:0]), .pc(pc), .bp_en(bp_en),
        .bp_addr(bp_addr), .cpu_rst(s_cpu_rst), .cpu_ce(s_cpu_ce), .busy(s_busy),
        .done(s_done), .bp_hit(s_bp_hit), .cycles(s_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in core: pc advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (cpu_ce) pc <= pc + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic release_and_check(input string tag);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("%s_cpu_rst_e%0d", tag, i), cpu_rst, (i < 4));
            check($sformatf("%s_ce_e%0d", tag, i), cpu_ce, 0);
        end
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] len);
        mode    = m;
        run_len = len;
        start   = 1'b1;
        pc_clr  = 1'b0;
        @(negedge clk);
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; start = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        run_len = '0; bp_en = 1'b0; bp_addr = '0; pc_clr = 1'b1;

        // 1: reset state and stretch
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ce", cpu_ce, 0);
        check("rst_done", done, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_cycles", cycles, 0);
        release_and_check("rel1");
        $display("test1 reset stretch complete");

        // 2: RUN_N for 5 cycles, then zero-length run
        launch(2'd3, 16'd5);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("run5_ce_%0d", i), cpu_ce, (i < 5));
            check($sformatf("run5_done_%0d", i), done, (i == 5));
            @(negedge clk);
        end
        check("run5_cycles", cycles, 5);
        check("run5_busy", busy, 0);
        launch(2'd3, 16'd0);
        check("run0_done", done, 1);
        check("run0_ce", cpu_ce, 0);
        check("run0_busy", busy, 0);
        @(negedge clk);
        check("run0_done_once", done, 0);
        check("run0_cycles", cycles, 0);
        $display("test2 run_n complete");

        // 3: STEP with one step_req landing in an enabled cycle
        launch(2'd2, 16'd0);
        check("step_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("step_ce_%0d", i), cpu_ce, (i == 3 || i == 7 || i == 11));
            step_req = (i == 2 || i == 6 || i == 10 || i == 11);
            @(negedge clk);
        end
        step_req = 1'b0;
        check("step_cycles", cycles, 3);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("step_halt_done", done, 1);
        check("step_halt_busy", busy, 0);
        $display("test3 step complete");

        // 4: FREE with breakpoint at 0x10
        pc_clr = 1'b1; bp_en = 1'b1; bp_addr = 32'h10;
        @(negedge clk);
        launch(2'd1, 16'd0);
        begin
            int k;
            k = 0;
            while (!done && k < 30) begin
                @(negedge clk);
                k++;
            end
            check("bp_wait_done", done, 1);
        end
        check("bp_hit_set", bp_hit, 1);
        check("bp_cycles", cycles, 5);
        check("bp_ce_off", cpu_ce, 0);
        check("bp_busy", busy, 0);
        bp_en = 1'b0;
        launch(2'd1, 16'd0);
        check("bp_cleared", bp_hit, 0);
        check("bp_restart_busy", busy, 1);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        $display("test4 breakpoint complete");

        // 5: halt and breakpoint coincide on 4th enabled cycle of RUN_N 10
        pc_clr = 1'b1; bp_en = 1'b1; bp_addr = 32'hC;
        @(negedge clk);
        launch(2'd3, 16'd10);
        repeat (3) @(negedge clk);
        check("prio_pc", pc, 32'hC);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("prio_done", done, 1);
        check("prio_bp_hit", bp_hit, 0);
        check("prio_busy", busy, 0);
        check("prio_cycles", cycles, 4);
        @(negedge clk);
        check("prio_done_once", done, 0);
        check("prio_ce", cpu_ce, 0);
        bp_en = 1'b0;

        // 5b: asynchronous reset in the middle of a FREE run
        launch(2'd1, 16'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cpu_rst", cpu_rst, 1);
        check("arst_ce", cpu_ce, 0);
        check("arst_busy", busy, 0);
        check("arst_cycles", cycles, 0);
        repeat (2) @(negedge clk);
        release_and_check("rel2");
        $display("test5 priority and async reset complete");

        // 6: 4-bit counter saturates during a 20-cycle FREE run
        launch(2'd1, 16'd0);
        repeat (20) @(negedge clk);
        check("sat_wide_cycles", cycles, 20);
        check("sat_narrow_cycles", s_cycles, 15);
        check("sat_narrow_busy", s_busy, 1);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("sat_narrow_done", s_done, 1);
        check("sat_narrow_hold", s_cycles, 15);
        $display("test6 saturation complete");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
